// File: rtl/ysyx_22040127_dmem_responder.sv
// Memory-side responder for the dcache refill/write-back port: serves burst reads
// and writes from an internal 64-bit word array after a fixed access latency.
module ysyx_22040127_dmem_responder #(
   parameter int MEM_WORDS = 4096,
   parameter int LATENCY   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [2:0]  req_len,
   input  logic        w_valid,
   output logic        w_ready,
   input  logic [63:0] w_data,
   input  logic [7:0]  w_strb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_last,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [2:0] {IDLE, WAIT, RD, WR, WACK} state_t;

   state_t      state, state_nxt;
   logic [63:0] mem [MEM_WORDS];
   logic [60:0] idx, beat_idx;
   logic [2:0]  len, cnt, beat_cnt;
   logic [3:0]  lat_cnt;
   logic        is_write, misaligned, err_acc;
   logic        rsp_fire, w_fire, beat_bad, load_beat;

   assign req_ready = (state == IDLE);
   assign w_ready   = (state == WR);
   assign busy      = (state != IDLE);
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign w_fire    = w_valid && w_ready;

   // A read beat handshake moves the pointer forward in the same cycle the next
   // beat is fetched, so the fetch looks one word ahead to keep beats back-to-back.
   always_comb begin
      beat_idx = idx;
      beat_cnt = cnt;
      if (state == RD && rsp_fire) begin
         beat_idx = idx + 61'd1;
         beat_cnt = cnt + 3'd1;
      end
      beat_bad  = misaligned || (beat_idx >= 61'(MEM_WORDS));
      load_beat = (state == RD) && (!rsp_valid || (rsp_ready && !rsp_last));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = (LATENCY > 0) ? WAIT : (req_write ? WR : RD);
         WAIT: if (lat_cnt <= 4'd1) state_nxt = is_write ? WR : RD;
         RD:   if (rsp_fire && rsp_last) state_nxt = IDLE;
         WR:   if (w_fire && cnt == len) state_nxt = WACK;
         WACK: if (rsp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx        <= '0;
         len        <= '0;
         cnt        <= '0;
         lat_cnt    <= '0;
         is_write   <= 1'b0;
         misaligned <= 1'b0;
         err_acc    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_last   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               idx        <= req_addr[63:3];
               len        <= req_len;
               is_write   <= req_write;
               misaligned <= |req_addr[2:0];
               cnt        <= '0;
               lat_cnt    <= 4'(LATENCY);
               err_acc    <= 1'b0;
            end
            WAIT: lat_cnt <= lat_cnt - 4'd1;
            RD: begin
               if (rsp_fire) begin
                  idx <= beat_idx;
                  cnt <= beat_cnt;
               end
               if (load_beat) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= beat_bad ? 64'd0 : mem[beat_idx[AW-1:0]];
                  rsp_err   <= beat_bad;
                  rsp_last  <= (beat_cnt == len);
               end else if (rsp_fire) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_last  <= 1'b0;
                  rsp_err   <= 1'b0;
               end
            end
            WR: if (w_fire) begin
               idx     <= idx + 61'd1;
               cnt     <= cnt + 3'd1;
               err_acc <= err_acc | beat_bad;
               if (cnt == len) begin
                  rsp_valid <= 1'b1;
                  rsp_last  <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= err_acc | beat_bad;
               end
            end
            WACK: if (rsp_fire) begin
               rsp_valid <= 1'b0;
               rsp_last  <= 1'b0;
               rsp_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Array has no reset; bad write beats are consumed but never land.
   always_ff @(posedge clk) begin
      if (w_fire && !beat_bad) begin
         for (int b = 0; b < 8; b++) begin
            if (w_strb[b]) mem[idx[AW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

endmodule
